rom_streamer: RTL and testbench

ROM_STREAMER -- requirements
Module: rom_streamer

---
 rtl/rom_streamer.sv | 138 +++++++++++++
 tb/tb_rom_streamer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_streamer.sv
// rom_streamer: reads a burst of consecutive words from a combinational ROM and
// hands them to a ready/valid consumer one word at a time. It also keeps a
// running sum of the accepted words. The FSM walks IDLE -> FETCH -> HOLD and
// loops through FETCH/HOLD once per word, then spends one DONE cycle before
// returning to IDLE.
module rom_streamer #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        start_addr,
  input  logic [ADDR_W:0]          count,
  input  logic                     abort,
  output logic [ADDR_W-1:0]        ROM_addr,
  input  logic [DATA_W-1:0]        ROM_data,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_W+ADDR_W-1:0] sum
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int SUM_W = DATA_W + ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic [SUM_W-1:0]   sum_q, sum_d;

  // A requested count of zero stands for a full sweep of the table.
  function automatic logic [CNT_W-1:0] burst_len(input logic [CNT_W-1:0] c);
    if (c == '0) begin
      return {1'b1, {ADDR_W{1'b0}}};
    end
    return c;
  endfunction

  // Accepted words are zero-extended; the sum width covers a full-table burst
  // of maximum words, so this never overflows.
  function automatic logic [SUM_W-1:0] add_word(input logic [SUM_W-1:0] acc,
                                                input logic [DATA_W-1:0] w);
    return acc + {{ADDR_W{1'b0}}, w};
  endfunction

  // Next-state and datapath updates; every register holds unless a rule moves it.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    sum_d   = sum_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = start_addr;
          rem_d   = burst_len(count);
          sum_d   = '0;
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (abort) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          data_d  = ROM_data;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end

      HOLD: begin
        // Abort beats a same-cycle handshake: the word is dropped, not summed.
        if (abort) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (valid_q && out_ready) begin
          sum_d   = add_word(sum_q, data_q);
          rem_d   = rem_q - CNT_W'(1);
          addr_d  = addr_q + ADDR_W'(1);
          valid_d = 1'b0;
          state_d = (rem_q == CNT_W'(1)) ? DONE : FETCH;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
    end
  end

  assign ROM_addr  = addr_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign sum       = sum_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_rom_streamer.sv
// Bench for rom_streamer: a queue-based model of the expected word stream,
// checked on every falling edge, plus directed bursts with literal results.
module tb_rom_streamer;

  localparam int AW = 3;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   count;
  logic          abort;
  logic [AW-1:0] ROM_addr;
  logic [DW-1:0] ROM_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic [DW+AW-1:0] sum;

  logic [DW-1:0] rom [8] = '{4'd0, 4'd12, 4'd6, 4'd7, 4'd8, 4'd1, 4'd13, 4'd14};
  assign ROM_data = rom[ROM_addr];

  always #5 clk = ~clk;

  rom_streamer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .count(count), .abort(abort), .ROM_addr(ROM_addr), .ROM_data(ROM_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .sum(sum)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int done_seen = 0;

  // Model: words still owed by the current burst, their addresses, the sum of
  // words accepted so far, and whether a done pulse is due this cycle.
  int wq[$];
  int aq[$];
  int model_sum = 0;
  bit exp_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out, got no event, expected one", name);
  endtask

  function automatic void model_load(input int sa, input int cn);
    int n;
    n = (cn == 0) ? 8 : cn;
    wq.delete();
    aq.delete();
    for (int i = 0; i < n; i++) begin
      aq.push_back((sa + i) % 8);
      wq.push_back(int'(rom[(sa + i) % 8]));
    end
    model_sum = 0;
  endfunction

  function automatic void model_flush();
    wq.delete();
    aq.delete();
    model_sum = 0;
    exp_done  = 1'b0;
  endfunction

  // Compare process: inputs are stable here, so this also predicts the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", busy, (wq.size() > 0 || exp_done) ? 1 : 0);
      chk("done", done, exp_done);
      if (done) done_seen++;
      exp_done = 1'b0;
      chk("sum", sum, model_sum);
      if (wq.size() > 0) begin
        chk("rom_addr", ROM_addr, aq[0]);
        if (out_valid) chk("out_data", out_data, wq[0]);
      end else begin
        chk("valid_idle", out_valid, 0);
      end
      if (abort && wq.size() > 0) begin
        wq.delete();
        aq.delete();
      end else if (out_valid && out_ready && wq.size() > 0) begin
        model_sum += wq[0];
        void'(wq.pop_front());
        void'(aq.pop_front());
        if (wq.size() == 0) exp_done = 1'b1;
      end
    end
  end

  task automatic start_burst(input logic [AW-1:0] sa, input logic [AW:0] cn);
    @(posedge clk);
    #1 start = 1'b1;
    start_addr = sa;
    count = cn;
    @(posedge clk);
    #1 start = 1'b0;
    model_load(int'(sa), int'(cn));
  endtask

  task automatic wait_done(input int max, output int cyc);
    cyc = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (done) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) timeout("wait_done");
    #1;
  endtask

  task automatic wait_valid(input int max);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) timeout("wait_valid");
  endtask

  initial begin
    int cyc;
    int d0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;
    start_addr = '0;
    count = '0;

    #2;
    chk("rst_rom_addr", ROM_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Full-table burst, consumer always ready.
    out_ready = 1'b1;
    d0 = done_seen;
    start_burst(3'd0, 4'd0);
    @(negedge clk);
    chk("lat_fetch_valid", out_valid, 0);
    @(negedge clk);
    chk("lat_hold_valid", out_valid, 1);
    chk("lat_first_word", out_data, 0);
    wait_done(40, cyc);
    chk("full_cycles", cyc, 15);
    chk("full_sum", sum, 61);
    chk("full_model_sum", model_sum, 61);
    chk("full_dones", done_seen - d0, 1);

    // Wrapping burst 6,7,0.
    d0 = done_seen;
    start_burst(3'd6, 4'd3);
    wait_done(20, cyc);
    chk("wrap_cycles", cyc, 7);
    chk("wrap_sum", sum, 27);
    chk("wrap_dones", done_seen - d0, 1);

    // Backpressure: first word held for five cycles.
    out_ready = 1'b0;
    start_burst(3'd1, 4'd2);
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 12);
      chk("bp_addr", ROM_addr, 1);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done(20, cyc);
    chk("bp_sum", sum, 18);

    // Abort on the second word while it is being accepted; stray start ignored.
    d0 = done_seen;
    start_burst(3'd2, 4'd4);
    @(posedge clk);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    start = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_sum", sum, 6);
    repeat (4) @(negedge clk);
    #1;
    chk("abort_no_done", done_seen - d0, 0);
    chk("abort_idle", busy, 0);

    // Asynchronous reset while a word is held, then a fresh one-word burst.
    out_ready = 1'b0;
    start_burst(3'd3, 4'd2);
    wait_valid(10);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rom_addr", ROM_addr, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_sum", sum, 0);
    model_flush();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    d0 = done_seen;
    start_burst(3'd4, 4'd1);
    wait_done(10, cyc);
    chk("post_rst_cycles", cyc, 3);
    chk("post_rst_sum", sum, 8);
    chk("post_rst_dones", done_seen - d0, 1);

    // Start held high: back-to-back single-word bursts, never sampled in DONE.
    d0 = done_seen;
    @(posedge clk);
    #1 start = 1'b1;
    start_addr = 3'd5;
    count = 4'd1;
    @(posedge clk);
    #1 model_load(5, 1);
    for (int b = 0; b < 2; b++) begin
      repeat (4) @(posedge clk);
      #1 model_load(5, 1);
    end
    start = 1'b0;
    wait_done(10, cyc);
    chk("held_cycles", cyc, 3);
    chk("held_sum", sum, 1);
    chk("held_dones", done_seen - d0, 3);
    repeat (3) @(negedge clk);
    #1;
    chk("held_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
